// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_controller_if #(
   parameter int OPCODE_W = 7,
   parameter int CNT_W    = 32
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                mem_req;
   logic                addr_src;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          result_src;
   logic [1:0]          alu_op;
   logic                we_ir;
   logic                we_pc;
   logic                we_reg;
   logic                we_mem;
   logic                instr_done;
   logic                illegal;
   logic                bus_fault;
   logic [CNT_W-1:0]    retired;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, addr_src, alu_src_a, alu_src_b, result_src, alu_op,
             we_ir, we_pc, we_reg, we_mem, instr_done, illegal, bus_fault, retired
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, addr_src, alu_src_a, alu_src_b, result_src, alu_op,
             we_ir, we_pc, we_reg, we_mem, instr_done, illegal, bus_fault, retired
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore mux selects and write enables per state,
// memory handshake with optional timeout, illegal-opcode trap, retire counter.
module multicycle_controller #(
   parameter int OPCODE_W     = 7,
   parameter int CNT_W        = 32,
   parameter int ENABLE_JUMPS = 1,
   parameter int MEM_TIMEOUT  = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.master bus
);
   localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
   localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I,
      ALUWB, BRANCH, JALR, JAL, JWB, TRAP
   } state_t;

   state_t           state, next;
   logic [TO_W-1:0]  wait_cnt, wait_nxt;
   logic [CNT_W-1:0] retired;
   logic             illegal, bus_fault, is_store;
   logic             in_wait, timeout, retire;
   logic             mem_req, addr_src, we_ir, we_pc, we_reg, we_mem;
   logic [1:0]       alu_src_a, alu_src_b, result_src, alu_op;

   // A stalled access times out on the cycle its wait count would reach the limit.
   assign in_wait = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign timeout = (MEM_TIMEOUT > 0) && in_wait && !bus.mem_ready &&
                    (int'(wait_cnt) == MEM_TIMEOUT - 1);

   always_comb begin
      next       = state;
      wait_nxt   = '0;
      mem_req    = 1'b0;
      addr_src   = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      result_src = 2'd0;
      alu_op     = 2'b00;
      we_ir      = 1'b0;
      we_pc      = 1'b0;
      we_reg     = 1'b0;
      we_mem     = 1'b0;
      retire     = 1'b0;
      if ((MEM_TIMEOUT > 0) && in_wait && !bus.mem_ready && !timeout)
         wait_nxt = wait_cnt + TO_W'(1);
      case (state)
         FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'd2;
            result_src = 2'd2;
            if (timeout) next = TRAP;
            else if (bus.mem_ready) begin
               we_ir = 1'b1;
               we_pc = 1'b1;
               next  = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            case (bus.opcode)
               OP_LOAD, OP_STORE: next = MEMADR;
               OP_RTYPE:          next = EXEC_R;
               OP_ITYPE:          next = EXEC_I;
               OP_BRANCH:         next = BRANCH;
               OP_JAL:            next = (ENABLE_JUMPS != 0) ? JAL  : TRAP;
               OP_JALR:           next = (ENABLE_JUMPS != 0) ? JALR : TRAP;
               default:           next = TRAP;
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            next      = is_store ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
            if (timeout) next = TRAP;
            else if (bus.mem_ready) next = MEMWB;
         end
         MEMWB: begin
            result_src = 2'd1;
            we_reg     = 1'b1;
            retire     = 1'b1;
            next       = FETCH;
         end
         MEMWRITE: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
            if (timeout) next = TRAP;
            else if (bus.mem_ready) begin
               we_mem = 1'b1;
               retire = 1'b1;
               next   = FETCH;
            end
         end
         EXEC_R: begin
            alu_src_a = 2'd2;
            alu_op    = 2'b10;
            next      = ALUWB;
         end
         EXEC_I: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            alu_op    = 2'b10;
            next      = ALUWB;
         end
         ALUWB, JWB: begin
            we_reg = 1'b1;
            retire = 1'b1;
            next   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 2'd2;
            alu_op    = 2'b01;
            we_pc     = bus.zero;
            retire    = 1'b1;
            next      = FETCH;
         end
         JALR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            next      = JAL;
         end
         JAL: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            we_pc     = 1'b1;
            next      = JWB;
         end
         TRAP:    next = TRAP;
         default: next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         retired   <= '0;
         illegal   <= 1'b0;
         bus_fault <= 1'b0;
      end else begin
         state    <= next;
         wait_cnt <= wait_nxt;
         if (retire) retired <= retired + CNT_W'(1);
         if ((next == TRAP) && (state != TRAP)) illegal <= 1'b1;
         if (timeout) bus_fault <= 1'b1;
      end
   end

   // Load/store direction only matters one cycle after DECODE, so no reset.
   always_ff @(posedge clk) begin
      if (state == DECODE) is_store <= (bus.opcode == OP_STORE);
   end

   // Requests and enables are forced low the instant reset asserts.
   assign bus.mem_req    = mem_req & rst_n;
   assign bus.we_ir      = we_ir & rst_n;
   assign bus.we_pc      = we_pc & rst_n;
   assign bus.we_reg     = we_reg & rst_n;
   assign bus.we_mem     = we_mem & rst_n;
   assign bus.instr_done = retire & rst_n;
   assign bus.addr_src   = addr_src;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.result_src = result_src;
   assign bus.alu_op     = alu_op;
   assign bus.illegal    = illegal;
   assign bus.bus_fault  = bus_fault;
   assign bus.retired    = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: one instance with jumps and a
// 4-cycle memory timeout, one with jumps disabled and no timeout.
module tb_multicycle_controller;
   typedef struct {
      int cycles;
      int we_reg;
      int we_mem;
      int we_pc;
      int we_ir;
      int retired;
   } exp_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       sel = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         exp_ret = 0;
   exp_t       sb[$];

   always #5 clk = ~clk;

   multicycle_controller_if #(.OPCODE_W(7), .CNT_W(32)) bus_m ();
   multicycle_controller_if #(.OPCODE_W(7), .CNT_W(32)) bus_n ();

   assign bus_m.opcode    = opcode;
   assign bus_m.zero      = zero;
   assign bus_m.mem_ready = mem_ready;
   assign bus_n.opcode    = opcode;
   assign bus_n.zero      = zero;
   assign bus_n.mem_ready = mem_ready;

   multicycle_controller #(.OPCODE_W(7), .CNT_W(32), .ENABLE_JUMPS(1), .MEM_TIMEOUT(4))
      u_main (.clk(clk), .rst_n(rst_n), .bus(bus_m));
   multicycle_controller #(.OPCODE_W(7), .CNT_W(32), .ENABLE_JUMPS(0), .MEM_TIMEOUT(0))
      u_nj (.clk(clk), .rst_n(rst_n), .bus(bus_n));

   logic        o_mem_req, o_we_ir, o_we_pc, o_we_reg, o_we_mem, o_instr_done;
   logic        o_illegal, o_bus_fault;
   logic [1:0]  o_alu_src_b;
   logic [31:0] o_retired;
   assign o_mem_req    = sel ? bus_n.mem_req    : bus_m.mem_req;
   assign o_we_ir      = sel ? bus_n.we_ir      : bus_m.we_ir;
   assign o_we_pc      = sel ? bus_n.we_pc      : bus_m.we_pc;
   assign o_we_reg     = sel ? bus_n.we_reg     : bus_m.we_reg;
   assign o_we_mem     = sel ? bus_n.we_mem     : bus_m.we_mem;
   assign o_instr_done = sel ? bus_n.instr_done : bus_m.instr_done;
   assign o_illegal    = sel ? bus_n.illegal    : bus_m.illegal;
   assign o_bus_fault  = sel ? bus_n.bus_fault  : bus_m.bus_fault;
   assign o_alu_src_b  = sel ? bus_n.alu_src_b  : bus_m.alu_src_b;
   assign o_retired    = sel ? bus_n.retired    : bus_m.retired;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench just after the active edge of the first FETCH cycle.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      exp_ret = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, "_rst_req"},     64'(o_mem_req),    64'd0);
      chk({tag, "_rst_retired"}, 64'(o_retired),    64'd0);
      chk({tag, "_rst_illegal"}, 64'(o_illegal),    64'd0);
      chk({tag, "_rst_fault"},   64'(o_bus_fault),  64'd0);
      chk({tag, "_rst_done"},    64'(o_instr_done), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk({tag, "_fetch"}, 64'({o_mem_req, o_alu_src_b}), 64'(3'b110));
   endtask

   // Memory answers each access after 'waits' stall cycles.
   task automatic run_instr(input string tag, input logic [6:0] opc, input logic z,
                            input int waits, input int e_cyc, input int e_reg,
                            input int e_mem, input int e_pc, input int e_ir);
      exp_t e;
      int   cyc, c_reg, c_mem, c_pc, c_ir, rc;
      bit   done;
      exp_ret++;
      e.cycles = e_cyc; e.we_reg = e_reg; e.we_mem = e_mem;
      e.we_pc = e_pc; e.we_ir = e_ir; e.retired = exp_ret;
      sb.push_back(e);
      opcode = opc;
      zero = z;
      cyc = 0; c_reg = 0; c_mem = 0; c_pc = 0; c_ir = 0; rc = 0; done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (o_mem_req) begin
            if (rc == waits) begin mem_ready = 1'b1; rc = 0; end
            else begin mem_ready = 1'b0; rc++; end
         end else begin
            mem_ready = 1'b0;
            rc = 0;
         end
         @(negedge clk);
         cyc++;
         c_reg += int'(o_we_reg);
         c_mem += int'(o_we_mem);
         c_pc  += int'(o_we_pc);
         c_ir  += int'(o_we_ir);
         if (o_instr_done) begin
            done = 1'b1;
            e = sb.pop_front();
            chk({tag, "_cycles"}, 64'(cyc),   64'(e.cycles));
            chk({tag, "_we_reg"}, 64'(c_reg), 64'(e.we_reg));
            chk({tag, "_we_mem"}, 64'(c_mem), 64'(e.we_mem));
            chk({tag, "_we_pc"},  64'(c_pc),  64'(e.we_pc));
            chk({tag, "_we_ir"},  64'(c_ir),  64'(e.we_ir));
         end
         @(posedge clk);
         #1;
      end
      chk({tag, "_retired_flag"}, 64'(done), 64'd1);
      if (done) chk({tag, "_retired"}, 64'(o_retired), 64'(e.retired));
   endtask

   task automatic run_trap(input string tag, input logic [6:0] opc);
      int cyc, act;
      cyc = 0;
      act = 0;
      opcode = opc;
      while (!o_illegal && cyc < 8) begin
         mem_ready = o_mem_req;
         @(posedge clk);
         #1 cyc++;
      end
      chk({tag, "_cycles"},  64'(cyc),       64'd2);
      chk({tag, "_illegal"}, 64'(o_illegal), 64'd1);
      for (int i = 0; i < 6; i++) begin
         mem_ready = ~mem_ready;
         @(negedge clk);
         act += int'(o_mem_req | o_we_ir | o_we_pc | o_we_reg | o_we_mem | o_instr_done);
         @(posedge clk);
         #1;
      end
      chk({tag, "_quiet"},   64'(act),       64'd0);
      chk({tag, "_retired"}, 64'(o_retired), 64'(exp_ret));
      chk({tag, "_sticky"},  64'(o_illegal), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int t_req, t_ir;
      sel = 1'b0;
      do_reset("m");
      run_instr("load",   OP_LOAD,   1'b0, 2, 9, 1, 0, 1, 1);
      run_instr("store",  OP_STORE,  1'b0, 0, 4, 0, 1, 1, 1);
      run_instr("beq_t",  OP_BRANCH, 1'b1, 0, 3, 0, 0, 2, 1);
      run_instr("beq_nt", OP_BRANCH, 1'b0, 0, 3, 0, 0, 1, 1);
      run_instr("rtype",  OP_RTYPE,  1'b0, 1, 5, 1, 0, 1, 1);
      run_instr("itype",  OP_ITYPE,  1'b0, 0, 4, 1, 0, 1, 1);
      run_instr("jal",    OP_JAL,    1'b0, 0, 4, 1, 0, 2, 1);
      run_instr("jalr",   OP_JALR,   1'b0, 0, 5, 1, 0, 2, 1);
      run_instr("st_edge", OP_STORE, 1'b0, 3, 10, 0, 1, 1, 1);
      chk("st_edge_nofault", 64'(o_bus_fault), 64'd0);
      run_trap("ill", 7'b0000000);

      do_reset("m2");
      chk("m2_illegal_clr", 64'(o_illegal), 64'd0);
      mem_ready = 1'b0;
      t_req = 0;
      t_ir = 0;
      for (int i = 0; i < 10 && !o_bus_fault; i++) begin
         @(negedge clk);
         t_req += int'(o_mem_req);
         t_ir  += int'(o_we_ir);
         @(posedge clk);
         #1;
      end
      chk("to_req_cycles", 64'(t_req),       64'd4);
      chk("to_we_ir",      64'(t_ir),        64'd0);
      chk("to_fault",      64'(o_bus_fault), 64'd1);
      chk("to_req_drop",   64'(o_mem_req),   64'd0);
      chk("to_retired",    64'(o_retired),   64'd0);

      do_reset("arst");
      opcode = OP_STORE;
      mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("arst_we_mem_pre", 64'(o_we_mem), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_we_mem", 64'(o_we_mem),     64'd0);
      chk("arst_req",    64'(o_mem_req),    64'd0);
      chk("arst_done",   64'(o_instr_done), 64'd0);
      @(posedge clk);
      #1 chk("arst_retired", 64'(o_retired), 64'd0);

      sel = 1'b1;
      do_reset("n");
      mem_ready = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("nto_fault", 64'(o_bus_fault), 64'd0);
      chk("nto_req",   64'(o_mem_req),   64'd1);
      run_instr("n_rtype", OP_RTYPE, 1'b0, 0, 4, 1, 0, 1, 1);
      run_trap("n_jal", OP_JAL);
      do_reset("n2");
      run_trap("n_jalr", OP_JALR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
